// File: rtl/lsu_switch_pkg.sv
// Shared definitions for the LSU memory switch: default widths, the
// address-type field layout and the request/response payload layouts.
package lsu_switch_pkg;

  localparam int NUM_LANES_DEF  = 4;
  localparam int WORD_SIZE_DEF  = 4;
  localparam int ADDR_WIDTH_DEF = 30;
  localparam int TAG_WIDTH_DEF  = 16;
  localparam int TYPE_BITS_DEF  = 2;
  localparam int SM_BIT_DEF     = 0;

  // Response source identifiers, also used as the round-robin pointer value
  typedef enum logic {
    SRC_CACHE = 1'b0,
    SRC_SMEM  = 1'b1
  } rsp_src_e;

  // Lane request payload at the default widths
  typedef struct packed {
    logic                        rw;
    logic [ADDR_WIDTH_DEF-1:0]   addr;
    logic [WORD_SIZE_DEF-1:0]    byteen;
    logic [8*WORD_SIZE_DEF-1:0]  data;
    logic [TAG_WIDTH_DEF-1:0]    tag;
  } lane_req_t;

  // Response payload at the default widths
  typedef struct packed {
    logic [NUM_LANES_DEF-1:0]                       tmask;
    logic [NUM_LANES_DEF-1:0][8*WORD_SIZE_DEF-1:0]  data;
    logic [TAG_WIDTH_DEF-1:0]                       tag;
  } rsp_t;

endpackage

// File: rtl/lsu_skid_buffer.sv
// Two-entry skid buffer with registered outputs. in_ready is a registered
// "not full" flag, so the upstream ready path never sees downstream logic.
// Slot p0 is the head (drives the output), slot p1 holds the overflow entry.
module lsu_skid_buffer #(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [DATAW-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  input  logic             out_ready
);

  logic             vld_p0;
  logic             vld_p1;
  logic [DATAW-1:0] data_p0;
  logic [DATAW-1:0] data_p1;
  logic             push;
  logic             pop;

  assign push      = in_valid && !vld_p1;
  assign pop       = vld_p0 && out_ready;
  assign in_ready  = !vld_p1;
  assign out_valid = vld_p0;
  assign out_data  = data_p0;

  // Occupancy tracking; the only state cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (pop) begin
      if (vld_p1) vld_p1 <= push;
      else        vld_p0 <= push;
    end else if (push) begin
      if (vld_p0) vld_p1 <= 1'b1;
      else        vld_p0 <= 1'b1;
    end
  end

  // Payload movement: head refills from the overflow slot on pop
  always_ff @(posedge clk) begin
    if (pop) begin
      if (vld_p1) begin
        data_p0 <= data_p1;
        if (push) data_p1 <= in_data;
      end else if (push) begin
        data_p0 <= in_data;
      end
    end else if (push) begin
      if (vld_p0) data_p1 <= in_data;
      else        data_p0 <= in_data;
    end
  end

endmodule

// File: rtl/lsu_mem_switch.sv
// LSU memory switch: routes each LSU lane request to the data cache or to
// shared memory based on the address-type bits in the tag, and merges the
// two response streams back to the LSU with a round-robin arbiter.
// Every output is driven from a skid buffer.
// Optional build macro: LSU_SWITCH_PERF_EN adds traffic/stall counters.
module lsu_mem_switch
  import lsu_switch_pkg::*;
#(
  parameter int NUM_LANES  = NUM_LANES_DEF,
  parameter int WORD_SIZE  = WORD_SIZE_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int TAG_WIDTH  = TAG_WIDTH_DEF,
  parameter int TYPE_BITS  = TYPE_BITS_DEF,
  parameter int SM_BIT     = SM_BIT_DEF
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_LANES-1:0]                    req_in_valid,
  input  logic [NUM_LANES-1:0]                    req_in_rw,
  input  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0]    req_in_addr,
  input  logic [NUM_LANES-1:0][WORD_SIZE-1:0]     req_in_byteen,
  input  logic [NUM_LANES-1:0][8*WORD_SIZE-1:0]   req_in_data,
  input  logic [NUM_LANES-1:0][TAG_WIDTH-1:0]     req_in_tag,
  output logic [NUM_LANES-1:0]                    req_in_ready,
  output logic [NUM_LANES-1:0]                    cache_req_valid,
  output logic [NUM_LANES-1:0]                    cache_req_rw,
  output logic [NUM_LANES-1:0][ADDR_WIDTH-1:0]    cache_req_addr,
  output logic [NUM_LANES-1:0][WORD_SIZE-1:0]     cache_req_byteen,
  output logic [NUM_LANES-1:0][8*WORD_SIZE-1:0]   cache_req_data,
  output logic [NUM_LANES-1:0][TAG_WIDTH-1:0]     cache_req_tag,
  input  logic [NUM_LANES-1:0]                    cache_req_ready,
  output logic [NUM_LANES-1:0]                    smem_req_valid,
  output logic [NUM_LANES-1:0]                    smem_req_rw,
  output logic [NUM_LANES-1:0][ADDR_WIDTH-1:0]    smem_req_addr,
  output logic [NUM_LANES-1:0][WORD_SIZE-1:0]     smem_req_byteen,
  output logic [NUM_LANES-1:0][8*WORD_SIZE-1:0]   smem_req_data,
  output logic [NUM_LANES-1:0][TAG_WIDTH-1:0]     smem_req_tag,
  input  logic [NUM_LANES-1:0]                    smem_req_ready,
  input  logic                                    cache_rsp_valid,
  input  logic [NUM_LANES-1:0]                    cache_rsp_tmask,
  input  logic [NUM_LANES-1:0][8*WORD_SIZE-1:0]   cache_rsp_data,
  input  logic [TAG_WIDTH-1:0]                    cache_rsp_tag,
  output logic                                    cache_rsp_ready,
  input  logic                                    smem_rsp_valid,
  input  logic [NUM_LANES-1:0]                    smem_rsp_tmask,
  input  logic [NUM_LANES-1:0][8*WORD_SIZE-1:0]   smem_rsp_data,
  input  logic [TAG_WIDTH-1:0]                    smem_rsp_tag,
  output logic                                    smem_rsp_ready,
  output logic                                    rsp_out_valid,
  output logic [NUM_LANES-1:0]                    rsp_out_tmask,
  output logic [NUM_LANES-1:0][8*WORD_SIZE-1:0]   rsp_out_data,
  output logic [TAG_WIDTH-1:0]                    rsp_out_tag,
  input  logic                                    rsp_out_ready
`ifdef LSU_SWITCH_PERF_EN
  ,
  output logic [43:0]                             perf_smem_reqs,
  output logic [43:0]                             perf_cache_reqs,
  output logic [43:0]                             perf_rsp_stalls
`endif
);

  typedef struct packed {
    logic                    rw;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [WORD_SIZE-1:0]    byteen;
    logic [8*WORD_SIZE-1:0]  data;
    logic [TAG_WIDTH-1:0]    tag;
  } req_pl_t;

  typedef struct packed {
    logic [NUM_LANES-1:0]                    tmask;
    logic [NUM_LANES-1:0][8*WORD_SIZE-1:0]   data;
    logic [TAG_WIDTH-1:0]                    tag;
  } rsp_pl_t;

  // Request side: one cache and one SMEM buffer per lane, lanes fully decoupled
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [TYPE_BITS-1:0] addr_type;
    logic                 sel_sm;
    logic                 cache_in_ready;
    logic                 smem_in_ready;
    req_pl_t              req_pl;
    req_pl_t              cache_pl;
    req_pl_t              smem_pl;

    assign addr_type       = req_in_tag[i][TYPE_BITS-1:0];
    assign sel_sm          = addr_type[SM_BIT];
    assign req_pl          = {req_in_rw[i], req_in_addr[i], req_in_byteen[i],
                              req_in_data[i], req_in_tag[i]};
    assign req_in_ready[i] = sel_sm ? smem_in_ready : cache_in_ready;

    lsu_skid_buffer #(.DATAW($bits(req_pl_t))) u_cache_buf (
      .clk       (clk),
      .rst       (reset),
      .in_valid  (req_in_valid[i] && !sel_sm),
      .in_data   (req_pl),
      .in_ready  (cache_in_ready),
      .out_valid (cache_req_valid[i]),
      .out_data  (cache_pl),
      .out_ready (cache_req_ready[i])
    );

    lsu_skid_buffer #(.DATAW($bits(req_pl_t))) u_smem_buf (
      .clk       (clk),
      .rst       (reset),
      .in_valid  (req_in_valid[i] && sel_sm),
      .in_data   (req_pl),
      .in_ready  (smem_in_ready),
      .out_valid (smem_req_valid[i]),
      .out_data  (smem_pl),
      .out_ready (smem_req_ready[i])
    );

    assign cache_req_rw[i]     = cache_pl.rw;
    assign cache_req_addr[i]   = cache_pl.addr;
    assign cache_req_byteen[i] = cache_pl.byteen;
    assign cache_req_data[i]   = cache_pl.data;
    assign cache_req_tag[i]    = cache_pl.tag;
    assign smem_req_rw[i]      = smem_pl.rw;
    assign smem_req_addr[i]    = smem_pl.addr;
    assign smem_req_byteen[i]  = smem_pl.byteen;
    assign smem_req_data[i]    = smem_pl.data;
    assign smem_req_tag[i]     = smem_pl.tag;
  end

  // Response side: round-robin between cache and SMEM into one buffer
  rsp_src_e rr_ptr;
  logic     grant_cache;
  logic     grant_smem;
  logic     rsp_in_valid;
  logic     rsp_in_ready;
  rsp_pl_t  rsp_in_pl;
  rsp_pl_t  rsp_out_pl;

  assign grant_cache     = cache_rsp_valid && (!smem_rsp_valid || rr_ptr == SRC_CACHE);
  assign grant_smem      = smem_rsp_valid && !grant_cache;
  assign rsp_in_valid    = grant_cache || grant_smem;
  assign rsp_in_pl       = grant_cache ? {cache_rsp_tmask, cache_rsp_data, cache_rsp_tag}
                                       : {smem_rsp_tmask, smem_rsp_data, smem_rsp_tag};
  assign cache_rsp_ready = grant_cache && rsp_in_ready;
  assign smem_rsp_ready  = grant_smem && rsp_in_ready;

  // Pointer moves to the source that was not served on every accepted response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= SRC_CACHE;
    end else if (rsp_in_valid && rsp_in_ready) begin
      rr_ptr <= grant_cache ? SRC_SMEM : SRC_CACHE;
    end
  end

  lsu_skid_buffer #(.DATAW($bits(rsp_pl_t))) u_rsp_buf (
    .clk       (clk),
    .rst       (reset),
    .in_valid  (rsp_in_valid),
    .in_data   (rsp_in_pl),
    .in_ready  (rsp_in_ready),
    .out_valid (rsp_out_valid),
    .out_data  (rsp_out_pl),
    .out_ready (rsp_out_ready)
  );

  assign rsp_out_tmask = rsp_out_pl.tmask;
  assign rsp_out_data  = rsp_out_pl.data;
  assign rsp_out_tag   = rsp_out_pl.tag;

`ifdef LSU_SWITCH_PERF_EN
  // Traffic counters per target and LSU-side response stall counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_smem_reqs  <= '0;
      perf_cache_reqs <= '0;
      perf_rsp_stalls <= '0;
    end else begin
      perf_smem_reqs  <= perf_smem_reqs + 44'($countones(smem_req_valid & smem_req_ready));
      perf_cache_reqs <= perf_cache_reqs + 44'($countones(cache_req_valid & cache_req_ready));
      if (rsp_out_valid && !rsp_out_ready) perf_rsp_stalls <= perf_rsp_stalls + 44'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_mem_switch.sv
// Scoreboard bench for lsu_mem_switch: accepted requests/responses are queued
// as expectations and popped when the switch emits them.
module tb_lsu_mem_switch;

  localparam int REQ_W = 83;
  localparam int RSP_W = 148;

  logic                clk = 1'b0;
  logic                reset;
  logic [3:0]          req_in_valid, req_in_rw, req_in_ready;
  logic [3:0][29:0]    req_in_addr;
  logic [3:0][3:0]     req_in_byteen;
  logic [3:0][31:0]    req_in_data;
  logic [3:0][15:0]    req_in_tag;
  logic [3:0]          cache_req_valid, cache_req_rw, cache_req_ready;
  logic [3:0][29:0]    cache_req_addr;
  logic [3:0][3:0]     cache_req_byteen;
  logic [3:0][31:0]    cache_req_data;
  logic [3:0][15:0]    cache_req_tag;
  logic [3:0]          smem_req_valid, smem_req_rw, smem_req_ready;
  logic [3:0][29:0]    smem_req_addr;
  logic [3:0][3:0]     smem_req_byteen;
  logic [3:0][31:0]    smem_req_data;
  logic [3:0][15:0]    smem_req_tag;
  logic                cache_rsp_valid, cache_rsp_ready;
  logic [3:0]          cache_rsp_tmask;
  logic [3:0][31:0]    cache_rsp_data;
  logic [15:0]         cache_rsp_tag;
  logic                smem_rsp_valid, smem_rsp_ready;
  logic [3:0]          smem_rsp_tmask;
  logic [3:0][31:0]    smem_rsp_data;
  logic [15:0]         smem_rsp_tag;
  logic                rsp_out_valid, rsp_out_ready;
  logic [3:0]          rsp_out_tmask;
  logic [3:0][31:0]    rsp_out_data;
  logic [15:0]         rsp_out_tag;
`ifdef LSU_SWITCH_PERF_EN
  logic [43:0]         perf_smem_reqs, perf_cache_reqs, perf_rsp_stalls;
`endif

  lsu_mem_switch dut (
    .clk(clk), .reset(reset),
    .req_in_valid(req_in_valid), .req_in_rw(req_in_rw), .req_in_addr(req_in_addr),
    .req_in_byteen(req_in_byteen), .req_in_data(req_in_data), .req_in_tag(req_in_tag),
    .req_in_ready(req_in_ready),
    .cache_req_valid(cache_req_valid), .cache_req_rw(cache_req_rw), .cache_req_addr(cache_req_addr),
    .cache_req_byteen(cache_req_byteen), .cache_req_data(cache_req_data), .cache_req_tag(cache_req_tag),
    .cache_req_ready(cache_req_ready),
    .smem_req_valid(smem_req_valid), .smem_req_rw(smem_req_rw), .smem_req_addr(smem_req_addr),
    .smem_req_byteen(smem_req_byteen), .smem_req_data(smem_req_data), .smem_req_tag(smem_req_tag),
    .smem_req_ready(smem_req_ready),
    .cache_rsp_valid(cache_rsp_valid), .cache_rsp_tmask(cache_rsp_tmask), .cache_rsp_data(cache_rsp_data),
    .cache_rsp_tag(cache_rsp_tag), .cache_rsp_ready(cache_rsp_ready),
    .smem_rsp_valid(smem_rsp_valid), .smem_rsp_tmask(smem_rsp_tmask), .smem_rsp_data(smem_rsp_data),
    .smem_rsp_tag(smem_rsp_tag), .smem_rsp_ready(smem_rsp_ready),
    .rsp_out_valid(rsp_out_valid), .rsp_out_tmask(rsp_out_tmask), .rsp_out_data(rsp_out_data),
    .rsp_out_tag(rsp_out_tag), .rsp_out_ready(rsp_out_ready)
`ifdef LSU_SWITCH_PERF_EN
    , .perf_smem_reqs(perf_smem_reqs), .perf_cache_reqs(perf_cache_reqs),
    .perf_rsp_stalls(perf_rsp_stalls)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [REQ_W-1:0] q_cache [4][$];
  logic [REQ_W-1:0] q_smem  [4][$];
  logic [RSP_W-1:0] q_rsp [$];
  logic [15:0]      seen_tags [$];
  logic [3:0]       last_acc;
  logic             last_cfire, last_sfire;
  logic             model_rr;    // 0: cache preferred, 1: smem preferred
  int               n_out;

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // One clock cycle: record what fires at the coming edge, then advance
  task automatic tick();
    logic [REQ_W-1:0] pl, ex;
    logic [RSP_W-1:0] rx;
    #1;
    last_acc   = req_in_valid & req_in_ready;
    last_cfire = cache_rsp_valid && cache_rsp_ready;
    last_sfire = smem_rsp_valid && smem_rsp_ready;
    for (int i = 0; i < 4; i++) begin
      pl = {req_in_rw[i], req_in_addr[i], req_in_byteen[i], req_in_data[i], req_in_tag[i]};
      if (last_acc[i]) begin
        if (req_in_tag[i][0]) q_smem[i].push_back(pl);
        else                  q_cache[i].push_back(pl);
      end
      if (cache_req_valid[i] && cache_req_ready[i]) begin
        if (q_cache[i].size() == 0) chk("cache_unexp", 160'(cache_req_valid[i]), 160'(0));
        else begin
          ex = q_cache[i].pop_front();
          chk("cache_req", 160'({cache_req_rw[i], cache_req_addr[i], cache_req_byteen[i],
                                 cache_req_data[i], cache_req_tag[i]}), 160'(ex));
        end
      end
      if (smem_req_valid[i] && smem_req_ready[i]) begin
        if (q_smem[i].size() == 0) chk("smem_unexp", 160'(smem_req_valid[i]), 160'(0));
        else begin
          ex = q_smem[i].pop_front();
          chk("smem_req", 160'({smem_req_rw[i], smem_req_addr[i], smem_req_byteen[i],
                                smem_req_data[i], smem_req_tag[i]}), 160'(ex));
        end
      end
    end
    if (cache_rsp_ready && smem_rsp_ready) chk("rsp_excl", 160'(smem_rsp_ready), 160'(0));
    if (cache_rsp_valid && smem_rsp_valid && (cache_rsp_ready || smem_rsp_ready))
      chk("rr_pick", 160'(smem_rsp_ready), 160'(model_rr));
    if (last_cfire) begin
      q_rsp.push_back({cache_rsp_tmask, cache_rsp_data, cache_rsp_tag});
      model_rr = 1'b1;
    end else if (last_sfire) begin
      q_rsp.push_back({smem_rsp_tmask, smem_rsp_data, smem_rsp_tag});
      model_rr = 1'b0;
    end
    if (rsp_out_valid && rsp_out_ready) begin
      n_out++;
      seen_tags.push_back(rsp_out_tag);
      if (q_rsp.size() == 0) chk("rsp_unexp", 160'(rsp_out_valid), 160'(0));
      else begin
        rx = q_rsp.pop_front();
        chk("rsp_out", 160'({rsp_out_tmask, rsp_out_data, rsp_out_tag}), 160'(rx));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_in_valid = '0; req_in_rw = '0; req_in_addr = '0; req_in_byteen = '0;
    req_in_data = '0; req_in_tag = '0;
    cache_rsp_valid = 1'b0; cache_rsp_tmask = '0; cache_rsp_data = '0; cache_rsp_tag = '0;
    smem_rsp_valid = 1'b0; smem_rsp_tmask = '0; smem_rsp_data = '0; smem_rsp_tag = '0;
  endtask

  task automatic clear_sb();
    for (int i = 0; i < 4; i++) begin
      q_cache[i].delete();
      q_smem[i].delete();
    end
    q_rsp.delete();
    seen_tags.delete();
    model_rr = 1'b0;
    n_out = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    cache_req_ready = '1; smem_req_ready = '1; rsp_out_ready = 1'b1;
    reset = 1'b1;
    clear_sb();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(input int n);
    idle_inputs();
    cache_req_ready = '1; smem_req_ready = '1; rsp_out_ready = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc, n_c;
    logic [15:0] ctag, stag;
    idle_inputs();
    cache_req_ready = '1; smem_req_ready = '1; rsp_out_ready = 1'b1;
    clear_sb();
    do_reset();

    // Reset state
    chk("rst_cache_vld", 160'(cache_req_valid), 160'(0));
    chk("rst_smem_vld",  160'(smem_req_valid),  160'(0));
    chk("rst_rsp_vld",   160'(rsp_out_valid),   160'(0));
    chk("rst_req_rdy",   160'(req_in_ready),    160'(4'hF));

    // Lane 0 to SMEM, lane 1 to cache in the same cycle
    req_in_valid = 4'b0011;
    req_in_rw[0] = 1'b1; req_in_addr[0] = 30'h0ABCDEF; req_in_byteen[0] = 4'hF;
    req_in_data[0] = 32'hDEADBEEF; req_in_tag[0] = 16'h0001;
    req_in_rw[1] = 1'b0; req_in_addr[1] = 30'h1234567; req_in_byteen[1] = 4'h3;
    req_in_data[1] = 32'hCAFEF00D; req_in_tag[1] = 16'h0000;
    tick();
    req_in_valid = '0;
    chk("t1_smem_vld",  160'(smem_req_valid),  160'(4'b0001));
    chk("t1_cache_vld", 160'(cache_req_valid), 160'(4'b0010));
    tick();
    chk("t1_drained", 160'(q_smem[0].size() + q_cache[1].size()), 160'(0));

    // Lane 2 SMEM back-pressure: two accepts fill the buffer, third waits
    smem_req_ready = '0;
    n_acc = 0;
    for (int c = 0; c < 6; c++) begin
      req_in_valid = 4'b0100;
      req_in_rw[2] = 1'(n_acc); req_in_addr[2] = 30'(32'h100 + n_acc);
      req_in_byteen[2] = 4'(n_acc + 1); req_in_data[2] = 32'hA000_0000 + 32'(n_acc);
      req_in_tag[2] = 16'(16'h0011 + 16'(n_acc << 4));
      tick();
      if (last_acc[2]) n_acc++;
    end
    chk("l2_acc_held",  160'(n_acc), 160'(2));
    chk("l2_ready_low", 160'(req_in_ready[2]), 160'(0));
    chk("l2_out_vld",   160'(smem_req_valid[2]), 160'(1));
    smem_req_ready = '1;
    for (int c = 0; c < 10; c++) begin
      if (n_acc < 3) begin
        req_in_valid = 4'b0100;
        req_in_rw[2] = 1'(n_acc); req_in_addr[2] = 30'(32'h100 + n_acc);
        req_in_byteen[2] = 4'(n_acc + 1); req_in_data[2] = 32'hA000_0000 + 32'(n_acc);
        req_in_tag[2] = 16'(16'h0011 + 16'(n_acc << 4));
      end else begin
        req_in_valid = '0;
      end
      tick();
      if (last_acc[2]) n_acc++;
    end
    chk("l2_all_acc", 160'(n_acc), 160'(3));
    chk("l2_drained", 160'(q_smem[2].size()), 160'(0));

    // Both response sources valid from reset: strict alternation
    do_reset();
    ctag = 16'h1000; stag = 16'h2001;
    for (int c = 0; c < 12 && seen_tags.size() < 4; c++) begin
      cache_rsp_valid = 1'b1; cache_rsp_tmask = 4'b1010;
      cache_rsp_data = {4{16'hC0DE, ctag}}; cache_rsp_tag = ctag;
      smem_rsp_valid = 1'b1; smem_rsp_tmask = 4'b0101;
      smem_rsp_data = {4{16'h5EED, stag}}; smem_rsp_tag = stag;
      tick();
      if (last_cfire) ctag = ctag + 16'd2;
      if (last_sfire) stag = stag + 16'd2;
    end
    chk("alt_count", 160'(seen_tags.size()), 160'(4));
    for (int k = 0; k < 4 && k < seen_tags.size(); k++)
      chk("alt_src", 160'(seen_tags[k][15:12]), 160'((k % 2 == 0) ? 1 : 2));
    drain(4);
    chk("alt_drained", 160'(q_rsp.size()), 160'(0));

    // Output stalled: only two cache responses can be absorbed
    do_reset();
    rsp_out_ready = 1'b0;
    n_c = 0; ctag = 16'h3000;
    for (int c = 0; c < 5; c++) begin
      cache_rsp_valid = 1'b1; cache_rsp_tmask = 4'(c + 1);
      cache_rsp_data = {4{16'hB0B0, ctag}}; cache_rsp_tag = ctag;
      tick();
      if (last_cfire) begin n_c++; ctag = ctag + 16'd2; end
    end
    chk("bp_buffered",  160'(n_c), 160'(2));
    chk("bp_cache_rdy", 160'(cache_rsp_ready), 160'(0));
    chk("bp_out_vld",   160'(rsp_out_valid), 160'(1));
    rsp_out_ready = 1'b1;
    for (int c = 0; c < 10 && n_c < 4; c++) begin
      cache_rsp_valid = 1'b1; cache_rsp_tmask = 4'(c + 6);
      cache_rsp_data = {4{16'hB0B0, ctag}}; cache_rsp_tag = ctag;
      tick();
      if (last_cfire) begin n_c++; ctag = ctag + 16'd2; end
    end
    drain(4);
    chk("bp_delivered", 160'(n_out), 160'(4));
    chk("bp_drained",   160'(q_rsp.size()), 160'(0));

    // Reset asserted with buffers full: everything is dropped at once
    do_reset();
    smem_req_ready = '0; rsp_out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      req_in_valid = 4'b1000; req_in_addr[3] = 30'(32'h200 + c);
      req_in_data[3] = 32'h7700 + 32'(c); req_in_tag[3] = 16'h0041;
      cache_rsp_valid = 1'b1; cache_rsp_tag = 16'(16'h4000 + 16'(c * 2));
      cache_rsp_tmask = 4'hF; cache_rsp_data = {4{32'h1234_0000 + 32'(c)}};
      tick();
    end
    idle_inputs();
    chk("pre_rst_rsp", 160'(rsp_out_valid), 160'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_rsp",  160'(rsp_out_valid),  160'(0));
    chk("rst_async_smem", 160'(smem_req_valid), 160'(0));
    clear_sb();
    cache_req_ready = '1; smem_req_ready = '1; rsp_out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) tick();
    chk("post_rst_quiet", 160'({rsp_out_valid, cache_req_valid, smem_req_valid}), 160'(0));
    chk("post_rst_nout",  160'(n_out), 160'(0));

`ifdef LSU_SWITCH_PERF_EN
    // Counters: 10 cycles, lanes 0/1 to SMEM, lanes 2/3 to cache
    do_reset();
    for (int c = 0; c < 10; c++) begin
      req_in_valid = 4'hF;
      for (int l = 0; l < 4; l++) begin
        req_in_addr[l] = 30'(c * 4 + l);
        req_in_data[l] = 32'(c * 16 + l);
        req_in_tag[l]  = 16'(16'(c << 4) | ((l < 2) ? 16'h0001 : 16'h0000));
      end
      tick();
    end
    drain(3);
    chk("perf_smem",   160'(perf_smem_reqs),  160'(20));
    chk("perf_cache",  160'(perf_cache_reqs), 160'(20));
    chk("perf_stalls", 160'(perf_rsp_stalls), 160'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
